// File: rtl/de2_issue_queue.sv
// de2_issue_queue: in-order issue buffer between Decode2 and the execute units.
// A circular FIFO of {unit, payload} entries. The head is presented to its one
// target unit and is released when that unit is ready. Head-of-line stalls are
// counted in a saturating counter. The FIFO is emptied by a pipeline flush.
module de2_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iFlush,
  input  logic                 iDe2Valid,
  input  logic [3:0]           iDe2Unit,
  input  logic [PAYLOAD_W-1:0] iDe2Payload,
  output logic                 oDe2Ready,
  input  logic [3:0]           iExReady,
  output logic [3:0]           oExValid,
  output logic [PAYLOAD_W-1:0] oExPayload,
  output logic [CNT_W-1:0]     oCount,
  output logic                 oIllegalUnit,
  output logic [15:0]          oStallCycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PAYLOAD_W + 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      stall_q, stall_d;

  // Entry storage. It is not reset: count and the pointers decide which slots are live.
  logic [ENT_W-1:0] entry_q [DEPTH];

  logic             not_empty;
  logic             push_try;
  logic             push;
  logic             pop;
  logic             handshake;
  logic [ENT_W-1:0] head;

  assign not_empty = (count_q != '0);

  // Readiness depends on registered occupancy only. A pop in the same cycle
  // therefore cannot make room for a push in that cycle.
  assign oDe2Ready = (count_q < DEPTH_C);

  assign push_try = iDe2Valid & oDe2Ready & ~iFlush;
  assign push     = push_try & $onehot(iDe2Unit);

  assign head       = entry_q[rd_ptr_q];
  assign oExValid   = not_empty ? head[ENT_W-1 -: 4] : 4'b0;
  assign oExPayload = not_empty ? head[PAYLOAD_W-1:0] : '0;

  // oExValid is one-hot or zero, so only the head unit's ready bit can matter.
  assign handshake = |(oExValid & iExReady);
  assign pop       = handshake & ~iFlush;

  assign oCount       = count_q;
  assign oIllegalUnit = illegal_q;
  assign oStallCycles = stall_q;

  // Next-state logic. Flush overrides push and pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = push_try & ~$onehot(iDe2Unit);
    stall_d   = stall_q;

    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // A stall is a cycle with an occupied head that is not taken. The counter saturates.
    if (not_empty && !handshake && !iFlush && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Control state register. Reset discards all entries at once.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  // Write an accepted entry into the tail slot.
  always_ff @(posedge iClk) begin
    if (push) entry_q[wr_ptr_q] <= {iDe2Unit, iDe2Payload};
  end

endmodule

// File: tb/tb_de2_issue_queue.sv
// tb_de2_issue_queue: directed and random stimulus for de2_issue_queue.
// The bench keeps a queue-based reference model of the issue buffer.
module tb_de2_issue_queue;

  localparam int DEPTH     = 4;
  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                 iClk;
  logic                 iRst;
  logic                 iFlush;
  logic                 iDe2Valid;
  logic [3:0]           iDe2Unit;
  logic [PAYLOAD_W-1:0] iDe2Payload;
  logic                 oDe2Ready;
  logic [3:0]           iExReady;
  logic [3:0]           oExValid;
  logic [PAYLOAD_W-1:0] oExPayload;
  logic [CNT_W-1:0]     oCount;
  logic                 oIllegalUnit;
  logic [15:0]          oStallCycles;

  de2_issue_queue #(
    .DEPTH     (DEPTH),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iFlush       (iFlush),
    .iDe2Valid    (iDe2Valid),
    .iDe2Unit     (iDe2Unit),
    .iDe2Payload  (iDe2Payload),
    .oDe2Ready    (oDe2Ready),
    .iExReady     (iExReady),
    .oExValid     (oExValid),
    .oExPayload   (oExPayload),
    .oCount       (oCount),
    .oIllegalUnit (oIllegalUnit),
    .oStallCycles (oStallCycles)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0]  unit;
    logic [63:0] pl;
  } ent_t;

  ent_t mq[$];
  int   exp_stall;
  bit   exp_illegal;
  int   errors;
  int   checks;
  int   cyc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [63:0] ep;
    ev = (mq.size() != 0) ? mq[0].unit : 4'b0;
    ep = (mq.size() != 0) ? mq[0].pl : 64'd0;
    check_eq("count",   64'(oCount), 64'(mq.size()));
    check_eq("ready",   64'(oDe2Ready), 64'(mq.size() < DEPTH));
    check_eq("exvalid", 64'(oExValid), 64'(ev));
    check_eq("payload", oExPayload, ep);
    check_eq("illegal", 64'(oIllegalUnit), 64'(exp_illegal));
    check_eq("stall",   64'(oStallCycles), 64'(exp_stall));
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic step(input logic v, input logic [3:0] u, input logic [63:0] p,
                      input logic [3:0] rdy, input logic fl, input bit chk);
    bit room, legal, do_push, do_pop;
    iDe2Valid   = v;
    iDe2Unit    = u;
    iDe2Payload = p;
    iExReady    = rdy;
    iFlush      = fl;
    @(negedge iClk);
    if (chk) begin
      check_outputs();
      $display("cyc %0d v=%0b u=%b p=%0h rdy=%b fl=%0b | cnt=%0d exv=%b expl=%0h ill=%0b stall=%0d",
               cyc, v, u, p, rdy, fl, oCount, oExValid, oExPayload, oIllegalUnit, oStallCycles);
    end
    room    = (mq.size() < DEPTH);
    legal   = ($countones(u) == 1);
    do_push = v && room && !fl && legal;
    do_pop  = (mq.size() != 0) && ((mq[0].unit & rdy) != 4'b0);
    @(posedge iClk);
    cyc++;
    if ((mq.size() != 0) && !do_pop && !fl)
      exp_stall = (exp_stall >= 65535) ? 65535 : exp_stall + 1;
    exp_illegal = v && room && !fl && !legal;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) mq.delete(0);
      if (do_push) mq.push_back('{unit: u, pl: p});
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] rdy);
    step(1'b0, 4'b0, 64'd0, rdy, 1'b0, 1'b1);
  endtask

  // Reset asserted between edges; the state must clear without waiting for a clock.
  task automatic async_reset();
    iRst = 1'b1;
    iDe2Valid = 1'b0;
    iFlush = 1'b0;
    iExReady = 4'b0;
    #2;
    mq.delete();
    exp_stall = 0;
    exp_illegal = 1'b0;
    check_outputs();
    iRst = 1'b0;
  endtask

  logic [3:0]  ru;
  logic [63:0] rp;

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    exp_stall = 0;
    exp_illegal = 1'b0;
    iRst = 1'b1;
    iFlush = 1'b0;
    iDe2Valid = 1'b0;
    iDe2Unit = 4'b0;
    iDe2Payload = '0;
    iExReady = 4'b0;
    #12;
    check_outputs();
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    // Single Int entry, then released by its unit.
    step(1'b1, 4'b0010, 64'h11, 4'b0000, 1'b0, 1'b1);
    idle(4'b0000);
    idle(4'b0010);
    idle(4'b0000);

    // Fill with Mem entries, a rejected fifth push, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0100, 64'hA0 + 64'(i), 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0100, 64'hA4, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle(4'b0100);

    // Keep two entries in flight while pushing and popping every cycle.
    step(1'b1, 4'b0010, 64'h100, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 64'h101, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0010, 64'h102 + 64'(i), 4'b0010, 1'b0, 1'b1);
    idle(4'b0010);
    idle(4'b0010);
    idle(4'b0000);

    // Head-of-line block: BJ head, Int behind it, every unit but BJ ready.
    step(1'b1, 4'b0001, 64'hB0, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 64'hB1, 4'b1110, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle(4'b1110);
    idle(4'b0001);
    idle(4'b0010);
    idle(4'b0000);

    // Non-one-hot units are rejected and pulse oIllegalUnit for one cycle.
    step(1'b1, 4'b0010, 64'hC0, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0110, 64'hC1, 4'b0000, 1'b0, 1'b1);
    idle(4'b0000);
    idle(4'b0000);
    step(1'b1, 4'b0000, 64'hC2, 4'b0000, 1'b0, 1'b1);
    idle(4'b0000);
    idle(4'b0000);

    // Flush with three entries and a colliding push, then a fresh push.
    step(1'b1, 4'b1000, 64'hD0, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 64'hD1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 64'hD2, 4'b0010, 1'b1, 1'b1);
    step(1'b1, 4'b0100, 64'hD3, 4'b0000, 1'b0, 1'b1);
    idle(4'b0000);
    idle(4'b0100);

    // Reset in the middle of traffic; the next push must come out normally.
    step(1'b1, 4'b0001, 64'hE0, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 64'hE1, 4'b0000, 1'b0, 1'b1);
    async_reset();
    step(1'b1, 4'b0100, 64'hE2, 4'b0000, 1'b0, 1'b1);
    idle(4'b0100);
    idle(4'b0000);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) ru = 4'($urandom_range(0, 15));
      else ru = 4'b0001 << $urandom_range(0, 3);
      rp = {32'($urandom), 32'($urandom)};
      step(1'($urandom_range(0, 9) < 6), ru, rp, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 29) == 0), 1'b1);
    end

    // Saturation: hold a BJ head with every other unit ready long enough to pin the counter.
    step(1'b0, 4'b0, 64'd0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 64'hF0, 4'b1110, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) step(1'b0, 4'b0, 64'd0, 4'b1110, 1'b0, 1'b0);
    idle(4'b1110);
    idle(4'b1110);
    idle(4'b0001);
    idle(4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/de2_issue_queue.md
Name: de2_issue_queue

Overview:
- In-order issue buffer between Decode2 and the execute units (BJ, Int, Mem, MultDiv).
- Accepts one decoded instruction per cycle from Decode2 and stores it in a circular FIFO.
- Presents the head entry to exactly one execute unit. It releases the head when that unit signals ready.
- Decouples execute-unit back-pressure from decode, counts head-of-line stall cycles, and clears on pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- PAYLOAD_W, 64, width of the decoded instruction payload produced by Decode2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  asynchronous active-high reset.
- iFlush  in  1  pipeline flush; clears all entries.
- iDe2Valid  in  1  Decode2 presents an instruction.
- iDe2Unit  in  4  one-hot target unit: bit0 BJ, bit1 Int, bit2 Mem, bit3 MultDiv.
- iDe2Payload  in  PAYLOAD_W  decoded instruction fields.
- oDe2Ready  out  1  queue can accept a push this cycle.
- iExReady  in  4  per-unit ready, same bit order as iDe2Unit.
- oExValid  out  4  per-unit valid; one-hot copy of the head unit, or 0 when empty.
- oExPayload  out  PAYLOAD_W  head payload; 0 when empty.
- oCount  out  CNT_W  current occupancy.
- oIllegalUnit  out  1  one-cycle pulse; the previous cycle's push was rejected for a non-one-hot unit.
- oStallCycles  out  16  saturating count of head-of-line stall cycles.

Behaviour:
- Reset (async, iRst=1): all pointers, count, oIllegalUnit and oStallCycles go to 0. Consequently oExValid=0, oExPayload=0, oDe2Ready=1. Entry storage is not reset.
- State: wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH, plus count of CNT_W bits. Each entry holds {unit[3:0], payload}.
- oDe2Ready = (count < DEPTH). It is derived from registered state only, with no combinational path from iExReady. A pop in the same cycle does not free a slot for a push in that cycle.
- Push accepted when: iDe2Valid & oDe2Ready & ~iFlush & ($countones(iDe2Unit)==1).
  - The entry is written at wr_ptr, and wr_ptr advances.
- Illegal push: iDe2Valid & oDe2Ready & ~iFlush with a non-one-hot iDe2Unit (zero or multiple bits set).
  - Nothing is written and the pointers are unchanged.
  - oIllegalUnit=1 on the next cycle only.
- Head outputs are combinational from state.
  - oExValid = (count!=0) ? head.unit : 4'b0.
  - oExPayload = (count!=0) ? head.payload : 0.
- Pop when: (count!=0) & |(oExValid & iExReady).
  - rd_ptr advances.
  - Ready bits for units other than the head unit are ignored.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur. Push and pop in the same cycle is legal whenever count is between 1 and DEPTH-1.
- Latency: an entry pushed in cycle N is visible at the head no earlier than cycle N+1. There is no bypass.
- Ordering: strictly in order. A stalled head blocks younger entries even if their units are ready.
- Flush (iFlush=1, synchronous, takes priority over push and pop):
  - count, wr_ptr and rd_ptr go to 0 on the next edge, and the push is ignored.
  - A handshake shown during the flush cycle is not re-presented; the execute units see the same flush and discard it.
  - oStallCycles is not cleared by flush.
- Stall counter: increments by 1 in each cycle where (count!=0) & ~|(oExValid & iExReady) & ~iFlush. It saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-operation: all entries are discarded immediately and asynchronously. The first push after iRst deasserts lands at slot 0.

Test Plan:
- Reset, then push Int payload 0x11 in cycle 1 with iExReady=0 -> cycle 2: oExValid=4'b0010, oExPayload=0x11, oCount=1. Raise iExReady[1] -> next cycle oCount=0, oExValid=0.
- Fill: push 4 Mem entries 0xA0..0xA3 with iExReady=0 -> oCount=4, oDe2Ready=0. A 5th push is ignored. Assert iExReady[2] for 4 cycles -> outputs 0xA0, 0xA1, 0xA2, 0xA3 in order, and oCount returns to 0.
- Wrap and simultaneous push/pop: keep oCount=2 while pushing and popping every cycle for 10 cycles with payload counting up -> pops appear in push order, oCount stays 2, and pointers wrap without loss.
- Head-of-line block: head BJ with iExReady=4'b1110 for 5 cycles, next entry Int -> no pop occurs, oStallCycles increases by 5, Int is not issued early.
- Illegal unit: push with iDe2Unit=4'b0110 -> oCount unchanged and oIllegalUnit=1 for exactly one cycle. A push with 4'b0000 behaves the same.
- Flush: with oCount=3, assert iFlush together with a valid push -> next cycle oCount=0 and oExValid=0. The following legal push appears as the head one cycle later.
